// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of one UART TX serializer
// between NUM_REQ byte streams, with optional source-ID header, CTS pause and inter-packet gap.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BITS  = 8,
    parameter int HEADER_EN  = 1,
    parameter int GAP_CYCLES = 16
) (
    input  logic                         ice_clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         cts_n,
    output logic                         tx_valid,
    output logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_ready,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy
);
    localparam int ptr_w = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int gap_w = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, HEADER, STREAM, GAP} state_t;

    state_t             state;
    logic [ptr_w-1:0]   ptr;
    logic [ptr_w-1:0]   win;
    logic [ptr_w-1:0]   idx;
    logic [gap_w-1:0]   gap_cnt;
    logic               found;
    logic [DATA_BITS-1:0] hdr;
    logic [DATA_BITS-1:0] cur;

    // Scan from farthest to nearest so the requester right after ptr wins.
    always_comb begin
        win   = ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ptr_w'((int'(ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // ptr always holds the current owner while a packet is in flight.
    assign hdr       = DATA_BITS'({4'hA, 4'(ptr)});
    assign cur       = req_data[int'(ptr)*DATA_BITS +: DATA_BITS];
    assign busy      = state != IDLE;
    assign tx_valid  = !cts_n && (state == HEADER || (state == STREAM && req_valid[ptr]));
    assign tx_data   = state == HEADER ? hdr : cur;
    assign req_ready = (state == STREAM && !cts_n && tx_ready) ? grant : '0;

    always_ff @(posedge ice_clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            ptr     <= ptr_w'(NUM_REQ - 1);
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (!cts_n && found) begin
                    grant <= NUM_REQ'(1) << win;
                    ptr   <= win;
                    state <= HEADER_EN != 0 ? HEADER : STREAM;
                end
                HEADER: if (tx_valid && tx_ready) state <= STREAM;
                STREAM: if (tx_valid && tx_ready && req_last[ptr]) begin
                    grant   <= '0;
                    gap_cnt <= gap_w'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
                    state   <= GAP_CYCLES == 0 ? IDLE : GAP;
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a
// packet-level round-robin model; a second instance covers the no-header, no-gap build.
module tb_uart_tx_arbiter;
    logic        ice_clk = 1'b0;
    logic        reset = 1'b1;
    logic        cts_n = 1'b0;
    logic        tx_ready = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last = '0;
    logic [31:0] req_data = '0;

    logic [3:0] rr_a, grant_a, rr_b, grant_b;
    logic       txv_a, busy_a, txv_b, busy_b;
    logic [7:0] txd_a, txd_b;

    always #5 ice_clk = ~ice_clk;

    uart_tx_arbiter dut_a (
        .ice_clk(ice_clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(rr_a), .cts_n(cts_n), .tx_valid(txv_a),
        .tx_data(txd_a), .tx_ready(tx_ready), .grant(grant_a), .busy(busy_a)
    );

    uart_tx_arbiter #(.HEADER_EN(0), .GAP_CYCLES(0)) dut_b (
        .ice_clk(ice_clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(rr_b), .cts_n(cts_n), .tx_valid(txv_b),
        .tx_data(txd_b), .tx_ready(tx_ready), .grant(grant_b), .busy(busy_b)
    );

    logic       sel = 1'b0;
    logic       m_txv, m_busy;
    logic [7:0] m_txd;
    logic [3:0] m_grant, m_rr;
    assign m_txv   = sel ? txv_b : txv_a;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_txd   = sel ? txd_b : txd_a;
    assign m_grant = sel ? grant_b : grant_a;
    assign m_rr    = sel ? rr_b : rr_a;

    int checks = 0, failures = 0, cyc = 0;
    logic [8:0] pk[4][64];
    int hd[4], tl[4], pops[4];
    bit started[4];
    int mode = 0, pat_i = 0;
    bit gaps = 1'b0;
    logic [3:0] pat = 4'b1001;
    logic [7:0] tx_log[$];
    int tx_cyc[$];
    logic [7:0] exp_q[$];
    logic tr_txv[8192], tr_busy[8192];
    logic [3:0] tr_grant[8192];
    logic s_txv, s_busy;
    logic [3:0] s_grant, s_rr;
    logic [7:0] s_txd, prev_data;
    int stall_err = 0, rr_err = 0;
    bit prev_stall = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [8:0] e;
        for (int i = 0; i < 4; i++) begin
            e = hd[i] < tl[i] ? pk[i][hd[i]] : 9'h0;
            req_valid[i] = hd[i] < tl[i] && !(gaps && started[i] && $urandom_range(0, 3) == 0);
            req_data[i*8 +: 8] = e[7:0];
            req_last[i] = e[8];
        end
        tx_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[2'(pat_i)] : $urandom_range(0, 2) != 0;
        if (mode == 2) cts_n = $urandom_range(0, 7) == 0;
    endtask

    // Observe at the falling edge; a byte moves on the next rising edge.
    task automatic step();
        bit pop[4];
        @(negedge ice_clk);
        cyc++;
        s_txv = m_txv; s_busy = m_busy; s_txd = m_txd; s_grant = m_grant; s_rr = m_rr;
        if (cyc < 8192) begin
            tr_txv[cyc] = m_txv; tr_busy[cyc] = m_busy; tr_grant[cyc] = m_grant;
        end
        if (m_txv && tx_ready) begin
            tx_log.push_back(m_txd);
            tx_cyc.push_back(cyc);
        end
        if (prev_stall && m_txv && m_txd !== prev_data) stall_err++;
        prev_stall = m_txv && !tx_ready;
        prev_data = m_txd;
        if ((m_rr & ~m_grant) != 0) rr_err++;
        if ((m_rr & req_valid) != 0 && !(m_txv && tx_ready)) rr_err++;
        for (int i = 0; i < 4; i++) pop[i] = req_valid[i] && m_rr[i];
        @(posedge ice_clk);
        #1;
        if (mode == 1) pat_i++;
        for (int i = 0; i < 4; i++) if (pop[i]) begin
            started[i] = !pk[i][hd[i]][8];
            hd[i]++;
            pops[i]++;
        end
        drive();
    endtask

    task automatic clear_q();
        for (int i = 0; i < 4; i++) begin
            hd[i] = 0; tl[i] = 0; pops[i] = 0; started[i] = 1'b0;
        end
        tx_log.delete();
        tx_cyc.delete();
        stall_err = 0;
        rr_err = 0;
        prev_stall = 1'b0;
    endtask

    task automatic do_reset();
        mode = 0; gaps = 1'b0; cts_n = 1'b0; reset = 1'b1;
        clear_q();
        drive();
        step();
        step();
        check("rst_grant", s_grant, 0);
        check("rst_tx_valid", s_txv, 0);
        check("rst_req_ready", s_rr, 0);
        check("rst_busy", s_busy, 0);
        reset = 1'b0;
    endtask

    task automatic add_byte(input int i, input logic [7:0] d, input bit last);
        pk[i][tl[i]] = {last, d};
        tl[i]++;
    endtask

    task automatic add_rand(input int i, input int n);
        for (int k = 0; k < n; k++) add_byte(i, 8'($urandom), k == n - 1);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < 4; i++) if (hd[i] != tl[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_done(input int limit);
        int n = 0;
        while (n < limit && !(all_empty() && !s_busy && !m_txv)) begin
            step();
            n++;
        end
        check("run_timeout", 32'(n < limit), 1);
    endtask

    // Packet-level reference: whole packets, owner chosen by rotating past the last owner.
    task automatic build_exp(input bit hen);
        int mh[4] = '{default: 0};
        int p = 3;
        int w;
        logic [8:0] e;
        exp_q.delete();
        while (1) begin
            w = -1;
            for (int k = 1; k <= 4; k++) if (mh[(p + k) % 4] < tl[(p + k) % 4]) begin
                w = (p + k) % 4;
                break;
            end
            if (w < 0) break;
            p = w;
            if (hen) exp_q.push_back({4'hA, 4'(w)});
            do begin
                e = pk[w][mh[w]];
                mh[w]++;
                exp_q.push_back(e[7:0]);
            end while (!e[8]);
        end
    endtask

    task automatic cmp_log(input string tag);
        check({tag, "_len"}, tx_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), tx_log[i], exp_q[i]);
    endtask

    initial begin
        int t, bad, n;
        drive();
        do_reset();

        add_byte(2, 8'h11, 0); add_byte(2, 8'h22, 0); add_byte(2, 8'h33, 1);
        drive();
        t = cyc + 1;
        step();
        check("p1_grant_t", s_grant, 0);
        step();
        check("p1_grant_t1", s_grant, 4'b0100);
        check("p1_txv_t1", s_txv, 1);
        check("p1_hdr_t1", s_txd, 8'hA2);
        run_done(200);
        build_exp(1);
        cmp_log("p1");
        check("p1_last_cyc", tx_cyc.size() >= 4 ? tx_cyc[3] : -1, t + 4);
        bad = 0;
        for (int c = t + 5; c <= t + 20; c++)
            if (!(tr_busy[c] === 1'b1 && tr_txv[c] === 1'b0 && tr_grant[c] === 4'b0)) bad++;
        check("p1_gap", bad, 0);
        check("p1_idle_after_gap", tr_busy[t + 21], 0);

        do_reset();
        add_rand(0, 1); add_rand(0, 1); add_rand(1, 1); add_rand(2, 1); add_rand(3, 1);
        drive();
        run_done(500);
        build_exp(1);
        cmp_log("rr");
        // 16 gap cycles plus the one IDLE arbitration cycle
        for (int p = 2; p <= 8; p += 2)
            check($sformatf("rr_space%0d", p), tx_cyc.size() > p ? tx_cyc[p] - tx_cyc[p-1] : -1, 18);

        do_reset();
        mode = 1; pat_i = 0;
        add_rand(1, 4);
        drive();
        run_done(500);
        build_exp(1);
        cmp_log("bp");
        check("bp_stall_stable", stall_err, 0);
        check("bp_ready_only_on_accept", rr_err, 0);
        check("bp_accept_count", pops[1], 4);

        do_reset();
        cts_n = 1'b1;
        add_rand(3, 3);
        drive();
        bad = 0;
        repeat (4) begin
            step();
            if (s_grant !== 4'b0 || s_busy !== 1'b0 || s_txv !== 1'b0) bad++;
        end
        check("cts_no_grant", bad, 0);
        cts_n = 1'b0;
        n = 0;
        while (tx_log.size() < 2 && n < 100) begin step(); n++; end
        check("cts_started", 32'(tx_log.size() >= 2), 1);
        cts_n = 1'b1;
        bad = 0;
        repeat (5) begin
            step();
            if (s_txv !== 1'b0 || s_grant !== 4'b1000 || s_rr !== 4'b0) bad++;
        end
        check("cts_pause", bad, 0);
        check("cts_pause_len", tx_log.size(), 2);
        cts_n = 1'b0;
        run_done(200);
        build_exp(1);
        cmp_log("cts");

        do_reset();
        add_rand(1, 4);
        drive();
        n = 0;
        while (tx_log.size() < 2 && n < 100) begin step(); n++; end
        check("mid_started", 32'(tx_log.size() >= 2), 1);
        reset = 1'b1;
        step();
        step();
        check("mid_rst_grant", s_grant, 0);
        check("mid_rst_txv", s_txv, 0);
        check("mid_rst_busy", s_busy, 0);
        reset = 1'b0;
        clear_q();
        add_rand(0, 1); add_rand(3, 1);
        drive();
        run_done(200);
        build_exp(1);
        cmp_log("rr03");
        check("rr03_first", tx_log.size() > 0 ? tx_log[0] : 8'h0, 8'hA0);

        for (int r = 0; r < 3; r++) begin
            do_reset();
            mode = 2; gaps = 1'b1;
            for (int i = 0; i < 4; i++)
                repeat ($urandom_range(0, 3)) add_rand(i, $urandom_range(1, 4));
            drive();
            run_done(3000);
            build_exp(1);
            cmp_log($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_stall", r), stall_err, 0);
            check($sformatf("rnd%0d_ready", r), rr_err, 0);
        end

        sel = 1'b1;
        do_reset();
        add_rand(1, 2); add_rand(2, 2);
        drive();
        t = cyc + 1;
        run_done(100);
        build_exp(0);
        cmp_log("nogap");
        check("nogap_c0", tx_cyc.size() > 0 ? tx_cyc[0] : -1, t + 1);
        check("nogap_c1", tx_cyc.size() > 1 ? tx_cyc[1] : -1, t + 2);
        check("nogap_c2", tx_cyc.size() > 2 ? tx_cyc[2] : -1, t + 4);
        check("nogap_c3", tx_cyc.size() > 3 ? tx_cyc[3] : -1, t + 5);
        check("nogap_bubble_idle", tr_busy[t + 3], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
